// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port, variable-latency memory between the
// instruction-fetch (IF) and data-memory (DM) requesters. Only one transaction
// is in flight at a time. DM has fixed priority, but IF is forced through once
// DM has won STARVE_LIMIT contested arbitrations in a row. A transaction that
// never completes is closed with an error response after TIMEOUT cycles.
module mem_port_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              dm_req,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [7:0]        dm_w_mask,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ready,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_err,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_w_mask,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam int TO_W = $clog2(TIMEOUT);
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);
  localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP
  } state_t;

  state_t            state;
  logic              owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        mask_q;
  logic [DATA_W-1:0] wdata_q;
  logic [SC_W-1:0]   starve_cnt;
  logic [TO_W-1:0]   to_cnt;

  logic if_force;
  logic if_win;
  logic dm_win;
  logic mem_done;
  logic to_expire;

  // Saturating increment of the starvation counter.
  function automatic logic [SC_W-1:0] starve_inc(input logic [SC_W-1:0] cnt);
    return (cnt == STARVE_MAX) ? cnt : cnt + SC_W'(1);
  endfunction

  // Winner selection; ready is held low while reset is asserted.
  assign if_force = (starve_cnt == STARVE_MAX);
  assign if_win   = rst && (state == ST_IDLE) && if_req && (!dm_req || if_force);
  assign dm_win   = rst && (state == ST_IDLE) && dm_req && !(if_req && if_force);
  assign if_ready = if_win;
  assign dm_ready = dm_win;

  // A response counts in RESP, or in REQ only together with the grant.
  assign mem_done  = mem_rvalid && ((state == ST_RESP) || ((state == ST_REQ) && mem_gnt));
  assign to_expire = (state != ST_IDLE) && !mem_done && (to_cnt == TO_LAST);

  assign mem_req    = (state == ST_REQ);
  assign mem_addr   = addr_q;
  assign mem_w_mask = mask_q;
  assign mem_wdata  = wdata_q;
  assign busy       = (state != ST_IDLE);
  assign owner      = owner_q;

  // Transaction FSM: accept in IDLE, request in REQ, wait in RESP, then pulse the owner.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      owner_q    <= 1'b0;
      addr_q     <= '0;
      mask_q     <= '0;
      wdata_q    <= '0;
      starve_cnt <= '0;
      to_cnt     <= '0;
      if_rvalid  <= 1'b0;
      if_rdata   <= '0;
      if_err     <= 1'b0;
      dm_rvalid  <= 1'b0;
      dm_rdata   <= '0;
      dm_err     <= 1'b0;
    end else begin
      if_rvalid <= 1'b0;
      if_err    <= 1'b0;
      dm_rvalid <= 1'b0;
      dm_err    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (if_win || dm_win) begin
            owner_q <= dm_win;
            addr_q  <= dm_win ? dm_addr : if_addr;
            mask_q  <= dm_win ? dm_w_mask : 8'h00;
            wdata_q <= dm_win ? dm_wdata : '0;
            to_cnt  <= '0;
            state   <= ST_REQ;
          end
          if (if_win) begin
            starve_cnt <= '0;
          end else if (dm_win && if_req) begin
            starve_cnt <= starve_inc(starve_cnt);
          end
        end
        ST_REQ, ST_RESP: begin
          if (mem_done || to_expire) begin
            state <= ST_IDLE;
            if (owner_q) begin
              dm_rvalid <= 1'b1;
              dm_err    <= to_expire;
              dm_rdata  <= mem_done ? mem_rdata : '0;
            end else begin
              if_rvalid <= 1'b1;
              if_err    <= to_expire;
              if_rdata  <= mem_done ? mem_rdata : '0;
            end
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
            if ((state == ST_REQ) && mem_gnt) begin
              state <= ST_RESP;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
